wbck_arb: RTL
=============

# wbck_arb

Writeback arbiter that shares the single integer register-file write port between the ALU (single-cycle) and the LSU (variable-latency load return). It sits between the execute units and the register file. It registers the winning write for one cycle and drives the retire pulse that frees the oldest entry of the writeback instruction track FIFO. It also keeps a small retired-write counter for performance monitoring.

## Interface
- DW, 64, write-data width
- AW, 5, register index width (matches RegAddrBus)
- CNTW, 32, retired-write counter width
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid / alu_ready  in / out  1  ALU writeback handshake
- alu_rd  in  AW  ALU destination index
- alu_wdata  in  DW  ALU result
- lsu_valid / lsu_ready  in / out  1  LSU writeback handshake
- lsu_rd  in  AW  LSU destination index
- lsu_wdata  in  DW  load data
- wb_stall  in  1  write port borrowed (debug/CSR); no grants while high
- rf_wen  out  1  register-file write enable (registered)
- rf_waddr  out  AW  register-file write index (registered)
- rf_wdata  out  DW  register-file write data (registered)
- isWB  out  1  one-cycle retire pulse to the track FIFO (registered)
- wb_cnt  out  CNTW  total retired writes, wraps modulo 2^CNTW

## Operation
- Transfer: a requester is granted when valid & ready. At most one grant per cycle.
- alu_ready and lsu_ready are combinational from the valid signals, wb_stall, and the arbitration state. When wb_stall=1, both readys are 0.
- Only one requester valid: it is granted.
- Both requesters valid: the winner is chosen by the policy in Configuration.
- Output stage: on a grant, the next cycle carries isWB=1, rf_waddr=rd, and rf_wdata=wdata. rf_wen=1 only if rd≠0.
  - A write to x0 still pulses isWB, because its track-FIFO entry must be freed.
- No grant in a cycle: the next cycle has rf_wen=0 and isWB=0. rf_waddr and rf_wdata hold their last values.
- wb_cnt increments by 1 for every isWB pulse, including x0 writes.
- A requester must hold valid, rd, and wdata stable until it is granted. The arbiter never drops a presented request.
- Reset values: rf_wen=0, isWB=0, rf_waddr=0, rf_wdata=0, wb_cnt=0, rr_ptr=ALU. While rst is high, both readys are 0.

## Timing
- Latency from grant to rf_wen/isWB is exactly 1 cycle. Throughput is 1 write per cycle.
- wb_stall asserted in cycle N blocks grants in cycle N only. A write already granted in N-1 still appears in N.
- Reset asserted mid-operation clears the output stage immediately, and any pending isWB is lost. The track FIFO is reset by the same rst, so it stays consistent.
- Simultaneous requests when the ALU wins: lsu_ready=0. The LSU retries next cycle with unchanged data.
- Back-to-back grants to the same rd are written in grant order. There is no merging.

## Configuration
- WBCK_ARB_RR_EN defined: round-robin between the two requesters.
  - A 1-bit rr_ptr names the preferred requester.
  - After a contested grant, rr_ptr points to the loser.
  - Uncontested grants leave rr_ptr unchanged.
- WBCK_ARB_RR_EN undefined: fixed priority, LSU over ALU, and rr_ptr is not instantiated.
  - Rationale: a load return cannot be replayed cheaply.
  - Starvation of the ALU is prevented upstream, because the ALU only issues after the track FIFO accepts.

## Structure
- Shared package/defines:
  - requester index constants (WB_REQ_ALU=0, WB_REQ_LSU=1);
  - AW/DW defaults via the existing RegAddrBus/XLEN defines.
- One sub-module, wbck_arb_pick: the two-input combinational grant logic plus rr_ptr update. It is configured by WBCK_ARB_RR_EN.
- Output stage and counter live in wbck_arb and use the codebase's Reg primitive with enable.

## Test plan
- Single ALU write: alu_valid=1, rd=5, data=0x1234 in cycle 0 -> alu_ready=1 in cycle 0; in cycle 1 rf_wen=1, rf_waddr=5, rf_wdata=0x1234, isWB=1; wb_cnt=1 in cycle 2.
- x0 write: lsu_valid=1, rd=0 -> next cycle rf_wen=0, isWB=1; wb_cnt increments.
- Contention with RR: both valid for 4 cycles with distinct rd -> grants alternate ALU, LSU, ALU, LSU (rr_ptr starts at ALU after reset). Without WBCK_ARB_RR_EN, LSU wins all 4 and alu_ready stays 0.
- Stall: both valid, wb_stall=1 for cycles 2–4 -> no readys in cycles 2–4; the grant in cycle 1 still produces rf_wen in cycle 2; grants resume in cycle 5 with the held data.
- Reset mid-flight: grant in cycle N, rst high during cycle N+1 -> rf_wen=0, isWB=0, wb_cnt=0 immediately; the requester is re-granted after rst deasserts.
- Counter wrap: CNTW=4 with 17 writes -> wb_cnt reads 1.

Source files
------------

// File: rtl/wbck_arb_pkg.sv
// Shared definitions for the writeback arbiter: requester indices and default widths.
// Combinational-only content; no latency.
// No backpressure of its own; consumers decide ready/valid behaviour.
package wbck_arb_pkg;

  // Default widths, matching the core's XLEN and RegAddrBus definitions.
  localparam int XLEN         = 64;
  localparam int REG_ADDR_BUS = 5;

  // Requester index: also the encoding of the round-robin preference pointer.
  typedef enum logic {
    WB_REQ_ALU = 1'b0,
    WB_REQ_LSU = 1'b1
  } wb_req_e;

endpackage

// File: rtl/wbck_arb_pick.sv
// Two-input writeback grant logic; with WBCK_ARB_RR_EN round-robin, else LSU-over-ALU priority.
// Combinational ready/grant; only the round-robin pointer is registered.
// Readys drop to 0 while rst or wb_stall is high; a losing requester simply sees ready=0.
module wbck_arb_pick
  import wbck_arb_pkg::*;
(
`ifdef WBCK_ARB_RR_EN
  input  logic    clk,
`endif
  input  logic    rst,
  input  logic    alu_valid,
  input  logic    lsu_valid,
  input  logic    wb_stall,
  output logic    alu_ready,
  output logic    lsu_ready,
  output logic    gnt_vld,
  output wb_req_e gnt_sel
);

  logic blk;
  logic gnt_alu;
  logic gnt_lsu;

`ifdef WBCK_ARB_RR_EN
  wb_req_e rr_ptr;

  // Preferred requester: after a contested grant, the loser becomes preferred.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= WB_REQ_ALU;
    end else if (alu_valid && lsu_valid && !blk) begin
      rr_ptr <= gnt_alu ? WB_REQ_LSU : WB_REQ_ALU;
    end
  end
`endif

  // Ready/grant decode; only contested cycles consult the policy.
  always_comb begin
    blk = rst | wb_stall;
`ifdef WBCK_ARB_RR_EN
    alu_ready = !blk && (!lsu_valid || (rr_ptr == WB_REQ_ALU));
    lsu_ready = !blk && (!alu_valid || (rr_ptr == WB_REQ_LSU));
`else
    // A load return cannot be replayed cheaply, so the LSU always wins.
    alu_ready = !blk && !lsu_valid;
    lsu_ready = !blk;
`endif
    gnt_alu = alu_valid && alu_ready;
    gnt_lsu = lsu_valid && lsu_ready;
    gnt_vld = gnt_alu || gnt_lsu;
    gnt_sel = gnt_lsu ? WB_REQ_LSU : WB_REQ_ALU;
  end

endmodule

// File: rtl/wbck_arb.sv
// Writeback arbiter sharing the register-file write port between ALU and LSU (WBCK_ARB_RR_EN selects round-robin).
// Grant to rf_wen/isWB latency is 1 cycle; 1 write per cycle throughput.
// Losing or stalled requesters see ready=0 and must hold their request; none is ever dropped.
module wbck_arb
  import wbck_arb_pkg::*;
#(
  parameter int DW   = XLEN,
  parameter int AW   = REG_ADDR_BUS,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [DW-1:0]   alu_wdata,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic            wb_stall,
  output logic            rf_wen,
  output logic [AW-1:0]   rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  output logic            isWB,
  output logic [CNTW-1:0] wb_cnt
);

  logic          gnt_vld;
  wb_req_e       gnt_sel;
  logic [AW-1:0] win_rd;
  logic [DW-1:0] win_wdata;

  wbck_arb_pick u_pick (
`ifdef WBCK_ARB_RR_EN
    .clk       (clk),
`endif
    .rst       (rst),
    .alu_valid (alu_valid),
    .lsu_valid (lsu_valid),
    .wb_stall  (wb_stall),
    .alu_ready (alu_ready),
    .lsu_ready (lsu_ready),
    .gnt_vld   (gnt_vld),
    .gnt_sel   (gnt_sel)
  );

  // Mux the winning requester's write onto the shared port.
  always_comb begin
    win_rd    = alu_rd;
    win_wdata = alu_wdata;
    if (gnt_sel == WB_REQ_LSU) begin
      win_rd    = lsu_rd;
      win_wdata = lsu_wdata;
    end
  end

  // Pulse stage: x0 writes still retire their track-FIFO entry but never enable the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isWB   <= 1'b0;
      rf_wen <= 1'b0;
    end else begin
      isWB   <= gnt_vld;
      rf_wen <= gnt_vld && (win_rd != '0);
    end
  end

  // Address/data register, loaded only on a grant so idle cycles hold the last write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (gnt_vld) begin
      rf_waddr <= win_rd;
      rf_wdata <= win_wdata;
    end
  end

  // Retired-write counter, bumped by each isWB pulse and wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_cnt <= '0;
    end else if (isWB) begin
      wb_cnt <= wb_cnt + CNTW'(1);
    end
  end

endmodule
